// File: rtl/axi_burst_addr_gen_if.sv
// Command-in / beat-out bundle for the AXI slave beat sequencer.
// The slave modport is the sequencer's view; master is the driver/consumer side.
interface axi_burst_addr_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ID_WIDTH-1:0]   cmd_id;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic [2:0]            cmd_size;
  logic [1:0]            cmd_burst;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [NB-1:0]         beat_strb;
  logic [7:0]            beat_idx;
  logic                  beat_last;
  logic [1:0]            beat_resp;

  modport slave (
    input  cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    output cmd_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_resp
  );

  modport master (
    output cmd_valid, cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
    input  cmd_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx, beat_last, beat_resp
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI AW/AR command into per-beat address, strobe, index and last,
// tagging illegal bursts (size, RSV, WRAP shape, 4KB crossing) with SLVERR.
module axi_burst_addr_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input logic                 ACLK,
  input logic                 ARESETn,
  axi_burst_addr_gen_if.slave bus
);
  localparam int unsigned NB      = DATA_WIDTH / 8;
  localparam int unsigned LOG2_NB = $clog2(NB);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(NB - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [1:0] B_FIXED = 2'd0;
  localparam logic [1:0] B_INCR  = 2'd1;
  localparam logic [1:0] B_WRAP  = 2'd2;
  localparam logic [1:0] B_RSV   = 2'd3;

  logic [0:0]            state;
  logic [ID_WIDTH-1:0]   id_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [ADDR_WIDTH-1:0] wrap_lower;
  logic [ADDR_WIDTH-1:0] wrap_end;
  logic [7:0]            len_r;
  logic [7:0]            idx_r;
  logic [2:0]            size_r;
  logic [1:0]            burst_r;
  logic                  err_r;
  logic [NB-1:0]         strb_r;

  function automatic logic [NB-1:0] lane_mask(input int unsigned lo, input int unsigned hi);
    logic [NB-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NB; i++) m[i] = (i >= lo) && (i <= hi);
    return m;
  endfunction

  // Acceptance-time decode: aligned address, wrap window and error checks.
  logic [ADDR_WIDTH-1:0] c_s;
  logic [ADDR_WIDTH-1:0] c_aligned;
  logic [ADDR_WIDTH-1:0] c_total;
  logic [ADDR_WIDTH-1:0] c_lower;
  logic [ADDR_WIDTH:0]   c_end;
  logic                  c_err;
  logic [NB-1:0]         c_strb;

  always_comb begin
    c_s       = ONE << bus.cmd_size;
    c_aligned = bus.cmd_addr & ~(c_s - ONE);
    c_total   = ADDR_WIDTH'({1'b0, bus.cmd_len} + 9'd1) << bus.cmd_size;
    c_lower   = bus.cmd_addr & ~(c_total - ONE);
    c_end     = {1'b0, c_aligned} + {1'b0, c_total} - {1'b0, ONE};
    c_err     = 1'b0;
    if (32'(bus.cmd_size) > LOG2_NB) c_err = 1'b1;
    if (bus.cmd_burst == B_RSV) c_err = 1'b1;
    if (bus.cmd_burst == B_WRAP &&
        !(bus.cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15})) c_err = 1'b1;
    if (bus.cmd_burst == B_WRAP && bus.cmd_addr != c_aligned) c_err = 1'b1;
    if (bus.cmd_burst == B_INCR && (c_end >> 12) != ({1'b0, bus.cmd_addr} >> 12)) c_err = 1'b1;
    c_strb = c_err ? '0 : lane_mask(32'(bus.cmd_addr & LANE_MASK),
                                    32'(c_aligned & LANE_MASK) + (32'd1 << bus.cmd_size) - 32'd1);
  end

  logic [ADDR_WIDTH-1:0] n_s;
  logic [ADDR_WIDTH-1:0] n_inc;
  logic [ADDR_WIDTH-1:0] n_wrap;
  logic [ADDR_WIDTH-1:0] n_addr;
  logic [NB-1:0]         n_strb;

  always_comb begin
    n_s    = ONE << size_r;
    n_inc  = (addr_r & ~(n_s - ONE)) + n_s;
    n_wrap = addr_r + n_s;
    case (burst_r)
      B_FIXED: n_addr = addr_r;
      B_WRAP:  n_addr = (n_wrap == wrap_end) ? wrap_lower : n_wrap;
      default: n_addr = n_inc;
    endcase
    if (err_r)                  n_strb = '0;
    else if (burst_r == B_FIXED) n_strb = strb_r;
    else n_strb = lane_mask(32'(n_addr & LANE_MASK),
                            32'(n_addr & LANE_MASK) + (32'd1 << size_r) - 32'd1);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      id_r       <= '0;
      addr_r     <= '0;
      wrap_lower <= '0;
      wrap_end   <= '0;
      len_r      <= '0;
      idx_r      <= '0;
      size_r     <= '0;
      burst_r    <= '0;
      err_r      <= 1'b0;
      strb_r     <= '0;
    end else begin
      case (state)
        IDLE: if (bus.cmd_valid) begin
          state      <= BURST;
          id_r       <= bus.cmd_id;
          addr_r     <= bus.cmd_addr;
          wrap_lower <= c_lower;
          wrap_end   <= c_lower + c_total;
          len_r      <= bus.cmd_len;
          idx_r      <= '0;
          size_r     <= bus.cmd_size;
          burst_r    <= bus.cmd_burst;
          err_r      <= c_err;
          strb_r     <= c_strb;
        end
        default: if (bus.beat_ready) begin
          if (idx_r == len_r) begin
            state <= IDLE;
          end else begin
            addr_r <= n_addr;
            idx_r  <= idx_r + 8'd1;
            strb_r <= n_strb;
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready  = (state == IDLE);
  assign bus.beat_valid = (state == BURST);
  assign bus.beat_id    = id_r;
  assign bus.beat_addr  = addr_r;
  assign bus.beat_strb  = strb_r;
  assign bus.beat_idx   = idx_r;
  assign bus.beat_last  = (state == BURST) && (idx_r == len_r);
  assign bus.beat_resp  = err_r ? 2'b10 : 2'b00;
endmodule
